// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one alu_dut between two requesters.
// One command is in flight at a time; the result returns with the requester id.
module alu_arbiter #(
  parameter int              DATA_W    = 32,
  parameter int              OP_W      = 3,
  parameter int              ALU_LAT   = 1,
  parameter logic [OP_W-1:0] ARITH_SEL = 3'b001,
  parameter logic [OP_W-1:0] SHIFT_SEL = 3'b000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_data1,
  input  logic [2*DATA_W-1:0] req_data2,
  input  logic [2*OP_W-1:0]   req_opselect,
  input  logic [2*OP_W-1:0]   req_operation,
  output logic [DATA_W-1:0]   aluin1,
  output logic [DATA_W-1:0]   aluin2,
  output logic [OP_W-1:0]     opselect,
  output logic [OP_W-1:0]     operation,
  output logic                enable_arith,
  output logic                enable_shift,
  input  logic [DATA_W-1:0]   aluout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_id,
  output logic                rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t              state;
  state_t              next_state;
  logic                last_grant;
  logic                grant;
  logic                accept;
  logic                cmd_id;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   sel_data1;
  logic [DATA_W-1:0]   sel_data2;
  logic [OP_W-1:0]     sel_opselect;
  logic [OP_W-1:0]     sel_operation;
  logic                sel_arith;
  logic                sel_shift;

  // Arbitration, operand selection and next-state logic.
  always_comb begin
    next_state    = state;
    req_ready     = 2'b00;
    accept        = 1'b0;
    grant         = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    sel_data1     = grant ? req_data1[2*DATA_W-1:DATA_W]   : req_data1[DATA_W-1:0];
    sel_data2     = grant ? req_data2[2*DATA_W-1:DATA_W]   : req_data2[DATA_W-1:0];
    sel_opselect  = grant ? req_opselect[2*OP_W-1:OP_W]    : req_opselect[OP_W-1:0];
    sel_operation = grant ? req_operation[2*OP_W-1:OP_W]   : req_operation[OP_W-1:0];
    sel_arith     = (sel_opselect == ARITH_SEL);
    // Arith wins if both selectors are ever configured to the same code.
    sel_shift     = (sel_opselect == SHIFT_SEL) && !sel_arith;
    case (state)
      S_IDLE: begin
        if (reset_n && (req_valid != 2'b00)) begin
          req_ready  = grant ? 2'b10 : 2'b01;
          accept     = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = (enable_arith || enable_shift) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State, command latch, ALU drive and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      cmd_id       <= 1'b0;
      cnt          <= 4'd0;
      aluin1       <= '0;
      aluin2       <= '0;
      opselect     <= '0;
      operation    <= '0;
      enable_arith <= 1'b0;
      enable_shift <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      state        <= next_state;
      enable_arith <= 1'b0;
      enable_shift <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            aluin1       <= sel_data1;
            aluin2       <= sel_data2;
            opselect     <= sel_opselect;
            operation    <= sel_operation;
            enable_arith <= sel_arith;
            enable_shift <= sel_shift;
            cmd_id       <= grant;
            last_grant   <= grant;
          end
        end
        S_ISSUE: begin
          if (enable_arith || enable_shift) begin
            cnt <= CNT_INIT;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= cmd_id;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= aluout;
            rsp_id    <= cmd_id;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with ALU_LAT=1 for the main vectors,
// a second with ALU_LAT=4 for the abort-by-reset sequence.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        reset_n_a = 1'b0;
  logic        reset_n_b = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_data1 = '0;
  logic [63:0] req_data2 = '0;
  logic [5:0]  req_opselect = '0;
  logic [5:0]  req_operation = '0;
  logic        rsp_ready = 1'b0;

  logic [1:0]  a_req_ready, b_req_ready;
  logic [31:0] a_aluin1, a_aluin2, b_aluin1, b_aluin2;
  logic [2:0]  a_opselect, a_operation, b_opselect, b_operation;
  logic        a_enable_arith, a_enable_shift, b_enable_arith, b_enable_shift;
  logic [31:0] a_aluout = '0;
  logic [31:0] b_aluout = '0;
  logic        a_rsp_valid, a_rsp_id, a_rsp_err, b_rsp_valid, b_rsp_id, b_rsp_err;
  logic [31:0] a_rsp_data, b_rsp_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        id;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  opsel;
    logic [2:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_arith;
    logic        exp_shift;
    int          exp_lat;
    int          bp;
  } vec_t;

  vec_t vecs[7];

  always #5 clock = ~clock;

  alu_arbiter #(.ALU_LAT(1)) dut_a (
    .clock(clock), .reset_n(reset_n_a),
    .req_valid(req_valid), .req_ready(a_req_ready),
    .req_data1(req_data1), .req_data2(req_data2),
    .req_opselect(req_opselect), .req_operation(req_operation),
    .aluin1(a_aluin1), .aluin2(a_aluin2), .opselect(a_opselect), .operation(a_operation),
    .enable_arith(a_enable_arith), .enable_shift(a_enable_shift), .aluout(a_aluout),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
    .rsp_id(a_rsp_id), .rsp_err(a_rsp_err)
  );

  alu_arbiter #(.ALU_LAT(4)) dut_b (
    .clock(clock), .reset_n(reset_n_b),
    .req_valid(req_valid), .req_ready(b_req_ready),
    .req_data1(req_data1), .req_data2(req_data2),
    .req_opselect(req_opselect), .req_operation(req_operation),
    .aluin1(b_aluin1), .aluin2(b_aluin2), .opselect(b_opselect), .operation(b_operation),
    .enable_arith(b_enable_arith), .enable_shift(b_enable_shift), .aluout(b_aluout),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
    .rsp_id(b_rsp_id), .rsp_err(b_rsp_err)
  );

  function automatic logic [31:0] alu_model(input logic ea, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    if (ea) begin
      case (op)
        3'd0:    return a + b;
        3'd1:    return a - b;
        3'd2:    return a & b;
        3'd3:    return a | b;
        3'd4:    return a ^ b;
        default: return a;
      endcase
    end
    case (op)
      3'd0:    return a << b[4:0];
      3'd1:    return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  // Behavioural ALUs: result visible ALU_LAT cycles after the enable pulse.
  always @(posedge clock) begin
    if (a_enable_arith || a_enable_shift)
      a_aluout <= alu_model(a_enable_arith, a_operation, a_aluin1, a_aluin2);
  end

  logic        b_pipe_v [3] = '{default: 1'b0};
  logic [31:0] b_pipe_d [3] = '{default: 32'h0};
  always @(posedge clock) begin
    b_pipe_v[0] <= b_enable_arith || b_enable_shift;
    b_pipe_d[0] <= alu_model(b_enable_arith, b_operation, b_aluin1, b_aluin2);
    for (int i = 1; i < 3; i++) begin
      b_pipe_v[i] <= b_pipe_v[i-1];
      b_pipe_d[i] <= b_pipe_d[i-1];
    end
    if (b_pipe_v[2]) b_aluout <= b_pipe_d[2];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one command on instance A and follows it to response handoff.
  task automatic apply_stimulus(input vec_t v);
    int lat;
    int na;
    int ns;
    if (v.id) begin
      req_data1 = {v.d1, ~v.d1};
      req_data2 = {v.d2, ~v.d2};
      req_opselect = {v.opsel, ~v.opsel};
      req_operation = {v.op, ~v.op};
    end else begin
      req_data1 = {~v.d1, v.d1};
      req_data2 = {~v.d2, v.d2};
      req_opselect = {~v.opsel, v.opsel};
      req_operation = {~v.op, v.op};
    end
    req_valid = v.id ? 2'b10 : 2'b01;
    rsp_ready = 1'b0;
    #1 check_output("req_ready_grant", 32'(a_req_ready), v.id ? 32'h2 : 32'h1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    check_output("issue_aluin1", a_aluin1, v.d1);
    check_output("issue_aluin2", a_aluin2, v.d2);
    check_output("issue_opselect", 32'(a_opselect), 32'(v.opsel));
    lat = 1;
    na = 0;
    ns = 0;
    while (!a_rsp_valid && lat < 30) begin
      if (a_enable_arith) na++;
      if (a_enable_shift) ns++;
      lat++;
      @(negedge clock);
    end
    check_output("rsp_latency", 32'(lat), 32'(v.exp_lat));
    check_output("arith_pulses", 32'(na), 32'(v.exp_arith));
    check_output("shift_pulses", 32'(ns), 32'(v.exp_shift));
    check_output("rsp_data", a_rsp_data, v.exp_data);
    check_output("rsp_err", 32'(a_rsp_err), 32'(v.exp_err));
    check_output("rsp_id", 32'(a_rsp_id), 32'(v.id));
    for (int c = 0; c < v.bp; c++) begin
      req_valid = 2'b11;
      #1 check_output("bp_req_ready", 32'(a_req_ready), 32'h0);
      @(negedge clock);
      check_output("bp_rsp_valid", 32'(a_rsp_valid), 32'h1);
      check_output("bp_rsp_data", a_rsp_data, v.exp_data);
      check_output("bp_rsp_id", 32'(a_rsp_id), 32'(v.id));
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check_output("rsp_cleared", 32'(a_rsp_valid), 32'h0);
  endtask

  initial begin
    int ng;
    int nr;
    int lat;
    logic seen;
    int g_id[4];
    int g_cyc[4];
    int r_id[4];
    int r_cyc[4];
    logic [31:0] r_data[4];

    //          id    d1            d2         opsel   op      exp_data      err   ar    sh    lat bp
    vecs[0] = '{1'b0, 32'h5,        32'h3,     3'b001, 3'b000, 32'h8,        1'b0, 1'b1, 1'b0, 3, 0};
    vecs[1] = '{1'b1, 32'h1,        32'h4,     3'b000, 3'b000, 32'h10,       1'b0, 1'b0, 1'b1, 3, 5};
    vecs[2] = '{1'b0, 32'h7,        32'h7,     3'b111, 3'b000, 32'h0,        1'b1, 1'b0, 1'b0, 2, 0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h1,     3'b001, 3'b000, 32'h0,        1'b0, 1'b1, 1'b0, 3, 0};
    vecs[4] = '{1'b0, 32'h80000000, 32'd31,    3'b000, 3'b001, 32'h1,        1'b0, 1'b0, 1'b1, 3, 0};
    vecs[5] = '{1'b1, 32'hF0F0,     32'h0FF0,  3'b001, 3'b100, 32'hFF00,     1'b0, 1'b1, 1'b0, 3, 2};
    vecs[6] = '{1'b1, 32'h1234,     32'h1,     3'b010, 3'b000, 32'h0,        1'b1, 1'b0, 1'b0, 2, 0};

    req_valid = 2'b11;
    repeat (3) @(negedge clock);
    check_output("reset_req_ready", 32'(a_req_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(a_rsp_valid), 32'h0);
    check_output("reset_enables", 32'({a_enable_arith, a_enable_shift}), 32'h0);
    check_output("reset_b_req_ready", 32'(b_req_ready), 32'h0);
    reset_n_a = 1'b1;
    #1 check_output("first_grant", 32'(a_req_ready), 32'h1);
    req_valid = 2'b00;
    @(negedge clock);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Both requesters valid with rsp_ready held high: alternating grants, 4-cycle period.
    req_data1 = {32'd200, 32'd100};
    req_data2 = {32'd2, 32'd1};
    req_opselect = {3'b001, 3'b001};
    req_operation = 6'b000000;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (a_req_ready != 2'b00 && ng < 4) begin
        g_id[ng] = int'(a_req_ready[1]);
        g_cyc[ng] = c;
        ng++;
      end
      if (a_rsp_valid && nr < 4) begin
        r_id[nr] = int'(a_rsp_id);
        r_data[nr] = a_rsp_data;
        r_cyc[nr] = c;
        nr++;
      end
      @(negedge clock);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check_output("fair_grants", 32'(ng), 32'd4);
    check_output("fair_rsps", 32'(nr), 32'd4);
    if (ng == 4 && nr == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_output("fair_grant_id", 32'(g_id[k]), 32'(k % 2));
        check_output("fair_rsp_id", 32'(r_id[k]), 32'(k % 2));
        check_output("fair_rsp_data", r_data[k], (k % 2) ? 32'd202 : 32'd101);
        check_output("fair_rsp_lat", 32'(r_cyc[k] - g_cyc[k]), 32'd3);
        if (k > 0) check_output("fair_period", 32'(g_cyc[k] - g_cyc[k-1]), 32'd4);
      end
    end

    // Abort in the middle of WAIT on the long-latency instance.
    @(negedge clock);
    reset_n_a = 1'b0;
    reset_n_b = 1'b1;
    req_data1 = {32'hDEAD, 32'h5};
    req_data2 = {32'hBEEF, 32'h3};
    req_opselect = {3'b001, 3'b001};
    req_operation = 6'b000000;
    req_valid = 2'b01;
    #1 check_output("b_first_grant", 32'(b_req_ready), 32'h1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    check_output("b_issue_arith", 32'(b_enable_arith), 32'h1);
    @(negedge clock);
    @(negedge clock);
    reset_n_b = 1'b0;
    #1;
    check_output("b_abort_aluin1", b_aluin1, 32'h0);
    check_output("b_abort_enables", 32'({b_enable_arith, b_enable_shift}), 32'h0);
    check_output("b_abort_rsp_valid", 32'(b_rsp_valid), 32'h0);
    @(negedge clock);
    reset_n_b = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (b_rsp_valid) seen = 1'b1;
    end
    check_output("b_no_stale_rsp", 32'(seen), 32'h0);

    req_data1 = {32'h1, 32'd9};
    req_data2 = {32'h1, 32'd6};
    req_valid = 2'b11;
    #1 check_output("b_regrant_req0", 32'(b_req_ready), 32'h1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    lat = 1;
    while (!b_rsp_valid && lat < 30) begin
      lat++;
      @(negedge clock);
    end
    check_output("b_rsp_latency", 32'(lat), 32'd6);
    check_output("b_rsp_data", b_rsp_data, 32'd15);
    check_output("b_rsp_id", 32'(b_rsp_id), 32'h0);
    check_output("b_rsp_err", 32'(b_rsp_err), 32'h0);
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check_output("b_rsp_cleared", 32'(b_rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu_dut instance between two independent command requesters.
- Accepts one command at a time using round-robin arbitration.
- Drives the ALU operand, operation, opselect and enable inputs for exactly one cycle, then waits a fixed ALU latency.
- Captures aluout and returns it with the requester ID on a valid/ready response port. Sits between the test/driver layer (or a future CPU front end) and alu_dut.

Parameters:
- DATA_W, 32, width of operands and result
- OP_W, 3, width of operation and opselect fields
- ALU_LAT, 1, clock cycles from enable pulse until aluout holds the result (range 1..15)
- ARITH_SEL, 3'b001, opselect value routed to enable_arith
- SHIFT_SEL, 3'b000, opselect value routed to enable_shift

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid; bit i = requester i
- req_ready  out  2  per-requester command accept
- req_data1  in  2*DATA_W  operand 1; slice i belongs to requester i
- req_data2  in  2*DATA_W  operand 2; slice i
- req_opselect  in  2*OP_W  opselect; slice i
- req_operation  in  2*OP_W  operation; slice i
- aluin1  out  DATA_W  to alu_dut aluin1
- aluin2  out  DATA_W  to alu_dut aluin2
- opselect  out  OP_W  to alu_dut opselect
- operation  out  OP_W  to alu_dut operation
- enable_arith  out  1  to alu_dut enable_arith
- enable_shift  out  1  to alu_dut enable_shift
- aluout  in  DATA_W  from alu_dut aluout
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  DATA_W  result
- rsp_id  out  1  requester that issued the command
- rsp_err  out  1  opselect matched neither ARITH_SEL nor SHIFT_SEL

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE; all registered outputs are 0 (aluin1, aluin2, opselect, operation, enable_*, rsp_*); last_grant=1, so requester 0 wins the first contest; wait counter=0.
- IDLE:
  - Grant = requester 0 or 1 if only that requester is valid; if both are valid, grant = ~last_grant.
  - req_ready is combinational, one-hot, only on the granted bit, and only in IDLE; otherwise 0.
  - Acceptance = req_valid[g] & req_ready[g]. On acceptance: latch the command fields, update last_grant=g, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive aluin1/aluin2/opselect/operation from the latched command.
  - enable_arith=1 if opselect==ARITH_SEL; enable_shift=1 if opselect==SHIFT_SEL. Never both.
  - If neither matches: no enable, rsp_err=1, rsp_data=0, go directly to RESP.
  - Otherwise load counter=ALU_LAT-1 and go to WAIT.
  - Operand/op outputs hold their values through WAIT; enables drop to 0 after ISSUE.
- WAIT: decrement the counter each cycle. When counter==0, register aluout into rsp_data, rsp_err=0, go to RESP.
- Latency: acceptance edge to rsp_valid=1 is ALU_LAT+2 cycles.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE. A new command may be accepted in the cycle after.
- Only one command is outstanding at a time; no command is accepted outside IDLE.
- A requester dropping req_valid before acceptance is legal; no state change.
- Reset asserted mid-operation aborts the command: no response is produced; enables go low immediately (asynchronously).
- rsp_ready held high continuously: back-to-back throughput is one command per ALU_LAT+3 cycles.

Test Plan:
- Reset: hold reset_n=0 with req_valid=2'b11 → req_ready=0, rsp_valid=0, enable_arith=enable_shift=0. Release → requester 0 granted first.
- Single arith (ALU_LAT=1): req0 data1=32'h5, data2=32'h3, opselect=3'b001, operation=3'b000.
  - enable_arith pulses exactly 1 cycle with aluin1=5, aluin2=3.
  - rsp_valid rises 3 cycles after acceptance with rsp_id=0 and rsp_data equal to the model aluout (8 for ADD), rsp_err=0.
- Fairness: both requesters continuously valid for 4 commands → grant order 0,1,0,1; rsp_id matches that order.
- Shift with backpressure: req1 opselect=3'b000, data1=32'h1, data2=32'h4; hold rsp_ready=0 for 5 cycles.
  - enable_shift pulses once; rsp_data/rsp_id stay constant.
  - req_ready stays 2'b00 until the response is taken.
- Illegal opselect=3'b111 from req0 → no enable pulse, rsp_err=1, rsp_data=0, rsp_valid 2 cycles after acceptance.
- Reset during WAIT (ALU_LAT=4, reset_n low at WAIT cycle 2) → no response after release; next command behaves as in the first-grant case.
